spi_xfer_ctrl: RTL and testbench

Byte-stream front end for the SPI master (CPOL=0, CPHA=1). It sits directly upstream of the master. It buffers host write bytes in a TX FIFO, issues one start pulse per byte on the master's start/busy/done handshake, and captures each received byte into an RX FIFO that the host drains over valid/ready. It guarantees the master only ever sees a rising start while busy=0, and that no received byte is lost.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_xfer_ctrl_if.sv | 38 +++
 rtl/spi_sync_fifo.sv | 54 +++++
 rtl/spi_xfer_ctrl.sv | 118 +++++++++++
 tb/tb_spi_xfer_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI transfer controller
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef logic [SPI_BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// rtl/spi_xfer_ctrl_if.sv - host byte streams and SPI master start/busy/done handshake
interface spi_xfer_ctrl_if;
    import spi_pkg::*;

    logic  s_tx_valid;
    logic  s_tx_ready;
    byte_t s_tx_data;

    logic  m_rx_valid;
    logic  m_rx_ready;
    byte_t m_rx_data;

    logic  spi_start;
    byte_t spi_tx_data;
    logic  spi_busy;
    logic  spi_done;
    byte_t spi_rx_data;

    // master: the transfer controller's view
    modport master (
        input  s_tx_valid, s_tx_data,
        output s_tx_ready,
        output m_rx_valid, m_rx_data,
        input  m_rx_ready,
        output spi_start, spi_tx_data,
        input  spi_busy, spi_done, spi_rx_data
    );

    modport slave (
        output s_tx_valid, s_tx_data,
        input  s_tx_ready,
        input  m_rx_valid, m_rx_data,
        output m_rx_ready,
        input  spi_start, spi_tx_data,
        output spi_busy, spi_done, spi_rx_data
    );

endinterface

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - first-word fall-through synchronous FIFO with flush and level
module spi_sync_fifo import spi_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int WIDTH = SPI_BYTE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // flush has priority over any same-cycle push or pop
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - byte-stream front end that feeds and drains an SPI master
module spi_xfer_ctrl import spi_pkg::*; #(
    parameter int FIFO_DEPTH = 8,
    parameter int BUSY_TMO   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          flush,
    spi_xfer_ctrl_if.master               bus,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          idle,
    output logic                          err_tmo,
    input  logic                          clr_err
);

    localparam int TW = $clog2(BUSY_TMO + 1);

    localparam logic [1:0] S_IDLE      = IDLE;
    localparam logic [1:0] S_START     = START;
    localparam logic [1:0] S_WAIT_BUSY = WAIT_BUSY;
    localparam logic [1:0] S_WAIT_DONE = WAIT_DONE;

    logic [1:0]    state;
    logic [TW-1:0] tmo_cnt;
    byte_t         tx_head;
    byte_t         rx_head;
    logic          tx_full, tx_empty;
    logic          rx_full, rx_empty;
    logic          launch;
    logic          timeout;
    logic          rx_push;

    // RX space is reserved before launch, so a result always has a slot
    assign launch  = (state == S_IDLE) && en && !tx_empty && !rx_full && !bus.spi_busy;
    assign timeout = (state == S_WAIT_BUSY) && !bus.spi_busy && (tmo_cnt == TW'(BUSY_TMO - 1));
    assign rx_push = (state == S_WAIT_DONE) && bus.spi_done;

    spi_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SPI_BYTE_W)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (bus.s_tx_valid),
        .push_data (bus.s_tx_data),
        .pop       (launch),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    spi_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SPI_BYTE_W)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (rx_push),
        .push_data (bus.spi_rx_data),
        .pop       (bus.m_rx_ready),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    assign bus.s_tx_ready = !tx_full;
    assign bus.m_rx_valid = !rx_empty;
    assign bus.m_rx_data  = rx_head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            bus.spi_start   <= 1'b0;
            bus.spi_tx_data <= '0;
            tmo_cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state           <= S_START;
                        bus.spi_start   <= 1'b1;
                        bus.spi_tx_data <= tx_head;
                    end
                end
                S_START: begin
                    state         <= S_WAIT_BUSY;
                    bus.spi_start <= 1'b0;
                    tmo_cnt       <= '0;
                end
                S_WAIT_BUSY: begin
                    // a timed-out byte is dropped; nothing reaches the RX FIFO
                    if (bus.spi_busy)  state <= S_WAIT_DONE;
                    else if (timeout)  state <= S_IDLE;
                    else               tmo_cnt <= tmo_cnt + 1'b1;
                end
                S_WAIT_DONE: begin
                    if (bus.spi_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       err_tmo <= 1'b0;
        else if (timeout) err_tmo <= 1'b1;
        else if (clr_err) err_tmo <= 1'b0;
    end

    assign idle = (state == S_IDLE) && tx_empty;

    a_start_single: assert property (@(posedge clk) disable iff (!rst_n)
        bus.spi_start |=> !bus.spi_start);

    a_rx_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        rx_push |-> !rx_full);

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - directed self-checking bench for spi_xfer_ctrl
module tb_spi_xfer_ctrl;
    import spi_pkg::*;

    localparam int DEPTH    = 8;
    localparam int TMO      = 4;
    localparam int XFER_CYC = 4;

    logic clk = 1'b0;
    logic rst_n, en, flush, clr_err;
    logic [3:0] tx_level, rx_level;
    logic idle, err_tmo;

    logic  no_busy, use_fixed;
    byte_t fixed_miso;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int mon_epoch = 0;
    int start_cnt, min_gap, last_done, dbl_start;
    logic prev_start;
    byte_t rxq[$];

    spi_xfer_ctrl_if bus();

    spi_xfer_ctrl #(.FIFO_DEPTH(DEPTH), .BUSY_TMO(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .flush    (flush),
        .bus      (bus),
        .tx_level (tx_level),
        .rx_level (rx_level),
        .idle     (idle),
        .err_tmo  (err_tmo),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI master model: busy in the start cycle, done pulse XFER_CYC cycles later
    initial begin : master_model
        int left;
        logic active;
        bus.spi_busy = 1'b0; bus.spi_done = 1'b0; bus.spi_rx_data = '0;
        active = 1'b0; left = 0;
        forever begin
            @(posedge clk); #1;
            bus.spi_done = 1'b0;
            if (!rst_n) begin
                bus.spi_busy = 1'b0; active = 1'b0;
            end else if (active) begin
                left--;
                if (left == 0) begin
                    bus.spi_busy = 1'b0; bus.spi_done = 1'b1; active = 1'b0;
                end
            end else if (bus.spi_start && !no_busy) begin
                bus.spi_busy = 1'b1; active = 1'b1; left = XFER_CYC;
                bus.spi_rx_data = use_fixed ? fixed_miso : ~bus.spi_tx_data;
            end
        end
    end

    initial begin : monitor
        int seen_epoch;
        seen_epoch = -1;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (seen_epoch != mon_epoch) begin
                seen_epoch = mon_epoch;
                start_cnt = 0; min_gap = 1000; last_done = -1; dbl_start = 0;
            end
            if (bus.spi_done) last_done = cyc;
            if (bus.spi_start) begin
                start_cnt++;
                if (prev_start) dbl_start++;
                if (last_done >= 0 && (cyc - last_done) < min_gap) min_gap = cyc - last_done;
            end
            prev_start = bus.spi_start;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_byte(input byte_t d);
        int w = 0;
        bus.s_tx_valid = 1'b1; bus.s_tx_data = d;
        while (!bus.s_tx_ready && w < 300) begin @(negedge clk); w++; end
        if (w >= 300) begin
            n_cmp++; n_fail++;
            $display("FAIL push_byte: byte %0h not accepted, ready stuck at %0b want 1", d, bus.s_tx_ready);
        end
        @(negedge clk);
        bus.s_tx_valid = 1'b0;
    endtask

    task automatic wait_start(output int w);
        w = 0;
        while (!bus.spi_start && w < 300) begin @(negedge clk); w++; end
        if (!bus.spi_start) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_start: spi_start=%0b after %0d cycles, want 1", bus.spi_start, w);
        end
    endtask

    task automatic wait_done();
        int w = 0;
        while (!bus.spi_done && w < 300) begin @(negedge clk); w++; end
        if (!bus.spi_done) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_done: spi_done=%0b after %0d cycles, want 1", bus.spi_done, w);
        end
    endtask

    task automatic drain(input int n);
        int w = 0;
        rxq.delete();
        bus.m_rx_ready = 1'b1;
        while (rxq.size() < n && w < 500) begin
            if (bus.m_rx_valid) rxq.push_back(bus.m_rx_data);
            @(negedge clk); w++;
        end
        bus.m_rx_ready = 1'b0;
        if (rxq.size() < n) begin
            n_cmp++; n_fail++;
            $display("FAIL drain: got %0d bytes want %0d", rxq.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.s_tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %0b want 1", bus.s_tx_ready); end
        n_cmp++; if (bus.m_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %0b want 0", bus.m_rx_valid); end
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0b want 1", idle); end
        n_cmp++; if (bus.spi_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0b want 0", bus.spi_start); end
        n_cmp++; if (bus.spi_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %0h want 0", bus.spi_tx_data); end
        n_cmp++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err_tmo); end
        n_cmp++; if (tx_level !== 4'd0 || rx_level !== 4'd0) begin n_fail++; $display("FAIL reset_levels: got %0d/%0d want 0/0", tx_level, rx_level); end
    endtask

    task automatic test_single();
        int w;
        mon_epoch++; use_fixed = 1'b1; fixed_miso = 8'h3C; en = 1'b1;
        @(negedge clk);
        bus.s_tx_valid = 1'b1; bus.s_tx_data = 8'hA5;
        @(negedge clk);
        bus.s_tx_valid = 1'b0;
        n_cmp++; if (bus.spi_start !== 1'b0) begin n_fail++; $display("FAIL single_early_start: got %0b want 0", bus.spi_start); end
        wait_start(w);
        n_cmp++; if (w !== 1) begin n_fail++; $display("FAIL single_latency: start %0d cycles late, want 1", w); end
        n_cmp++; if (bus.spi_tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_tx_data: got %0h want a5", bus.spi_tx_data); end
        wait_done();
        n_cmp++; if (bus.m_rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_rx_early: got %0b want 0", bus.m_rx_valid); end
        @(negedge clk);
        n_cmp++; if (bus.m_rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_rx_valid: got %0b want 1", bus.m_rx_valid); end
        n_cmp++; if (bus.m_rx_data !== 8'h3C) begin n_fail++; $display("FAIL single_rx_data: got %0h want 3c", bus.m_rx_data); end
        drain(1);
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %0b want 1", idle); end
        n_cmp++; if (start_cnt !== 1) begin n_fail++; $display("FAIL single_starts: got %0d want 1", start_cnt); end
        use_fixed = 1'b0;
    endtask

    task automatic test_burst();
        byte_t e;
        mon_epoch++; en = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) push_byte(byte_t'(i));
        n_cmp++; if (tx_level !== 4'd8) begin n_fail++; $display("FAIL burst_level: got %0d want 8", tx_level); end
        n_cmp++; if (bus.s_tx_ready !== 1'b0) begin n_fail++; $display("FAIL burst_ready: got %0b want 0", bus.s_tx_ready); end
        en = 1'b1;
        drain(8);
        for (int i = 0; i < rxq.size(); i++) begin
            e = ~byte_t'(i + 1);
            n_cmp++; if (rxq[i] !== e) begin n_fail++; $display("FAIL burst_rx[%0d]: got %0h want %0h", i, rxq[i], e); end
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (start_cnt !== 8) begin n_fail++; $display("FAIL burst_starts: got %0d want 8", start_cnt); end
        n_cmp++; if (!(min_gap >= 2)) begin n_fail++; $display("FAIL burst_gap: got %0d want >=2", min_gap); end
        n_cmp++; if (dbl_start !== 0) begin n_fail++; $display("FAIL burst_start_width: got %0d wide pulses want 0", dbl_start); end
    endtask

    task automatic test_backpressure();
        byte_t e;
        int w = 0;
        mon_epoch++; en = 1'b1; bus.m_rx_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) push_byte(byte_t'(8'h10 + i));
        while (rx_level != 4'd8 && w < 300) begin @(negedge clk); w++; end
        repeat (10) @(negedge clk);
        n_cmp++; if (rx_level !== 4'd8) begin n_fail++; $display("FAIL bp_rx_level: got %0d want 8", rx_level); end
        n_cmp++; if (tx_level !== 4'd2) begin n_fail++; $display("FAIL bp_tx_level: got %0d want 2", tx_level); end
        n_cmp++; if (start_cnt !== 8) begin n_fail++; $display("FAIL bp_starts: got %0d want 8", start_cnt); end
        drain(10);
        for (int i = 0; i < rxq.size(); i++) begin
            e = ~byte_t'(8'h10 + i);
            n_cmp++; if (rxq[i] !== e) begin n_fail++; $display("FAIL bp_rx[%0d]: got %0h want %0h", i, rxq[i], e); end
        end
    endtask

    task automatic test_timeout();
        int w;
        mon_epoch++; no_busy = 1'b1; en = 1'b1;
        @(negedge clk);
        push_byte(8'h55);
        wait_start(w);
        repeat (TMO) @(negedge clk);
        n_cmp++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %0b want 0", err_tmo); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_cmp++; if (err_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_set_wins: got %0b want 1", err_tmo); end
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL tmo_idle: got %0b want 1", idle); end
        no_busy = 1'b0;
        push_byte(8'h66);
        wait_start(w);
        n_cmp++; if (bus.spi_tx_data !== 8'h66) begin n_fail++; $display("FAIL tmo_next_tx: got %0h want 66", bus.spi_tx_data); end
        wait_done();
        @(negedge clk);
        n_cmp++; if (rx_level !== 4'd1) begin n_fail++; $display("FAIL tmo_rx_level: got %0d want 1", rx_level); end
        n_cmp++; if (bus.m_rx_data !== 8'h99) begin n_fail++; $display("FAIL tmo_rx_data: got %0h want 99", bus.m_rx_data); end
        n_cmp++; if (err_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %0b want 1", err_tmo); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_cmp++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %0b want 0", err_tmo); end
        drain(1);
    endtask

    task automatic test_flush();
        int w;
        mon_epoch++; en = 1'b0; bus.m_rx_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_byte(byte_t'(8'h21 + i));
        en = 1'b1;
        wait_start(w);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (tx_level !== 4'd0) begin n_fail++; $display("FAIL flush_tx_level: got %0d want 0", tx_level); end
        n_cmp++; if (rx_level !== 4'd0) begin n_fail++; $display("FAIL flush_rx_level: got %0d want 0", rx_level); end
        wait_done();
        @(negedge clk);
        n_cmp++; if (rx_level !== 4'd1) begin n_fail++; $display("FAIL flush_inflight_level: got %0d want 1", rx_level); end
        n_cmp++; if (bus.m_rx_data !== 8'hDE) begin n_fail++; $display("FAIL flush_inflight_data: got %0h want de", bus.m_rx_data); end
        repeat (10) @(negedge clk);
        n_cmp++; if (start_cnt !== 1) begin n_fail++; $display("FAIL flush_starts: got %0d want 1", start_cnt); end
        drain(1);
    endtask

    task automatic test_reset_mid();
        int w;
        mon_epoch++; en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) push_byte(byte_t'(8'h31 + i));
        en = 1'b1;
        wait_start(w);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.spi_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_start: got %0b want 0", bus.spi_start); end
        n_cmp++; if (bus.spi_tx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx_data: got %0h want 0", bus.spi_tx_data); end
        n_cmp++; if (tx_level !== 4'd0 || rx_level !== 4'd0) begin n_fail++; $display("FAIL rstmid_levels: got %0d/%0d want 0/0", tx_level, rx_level); end
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle: got %0b want 1", idle); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (start_cnt !== 1) begin n_fail++; $display("FAIL rstmid_starts: got %0d want 1", start_cnt); end
        n_cmp++; if (bus.m_rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid: got %0b want 0", bus.m_rx_valid); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        no_busy = 1'b0; use_fixed = 1'b0; fixed_miso = '0;
        bus.s_tx_valid = 1'b0; bus.s_tx_data = '0; bus.m_rx_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_timeout();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
